// File: rtl/free_list.sv
// free_list: circular FIFO of free physical-register tags for a renaming stage.
//   Dispatch pops a tag from the head (fall-through, no bypass). Retire and
//   rollback push released tags at the tail, up to two per cycle. Pushes
//   beyond capacity are dropped and raise a sticky overflow flag.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   alloc            - dispatch wants a new tag
//   hazard_stall     - pipeline stall, blocks allocation
//   PR_new           - tag at the FIFO head (combinational read)
//   empty            - no free tag available
//   retire_reg       - ROB retiring an instruction
//   RegDest_retire   - retiring instruction wrote a register
//   PR_old_RT        - superseded tag released at retire
//   recover          - ROB rollback in progress (also blocks allocation)
//   RegDest_out      - flushed entry wrote a register
//   PR_new_flush     - speculative tag released on flush
//   free_count       - number of free tags (registered)
//   overflow         - sticky capacity error, cleared only by reset
module free_list #(
  parameter int unsigned NUM_PR = 64,
  parameter int unsigned NUM_AR = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 alloc,
  input  logic                                 hazard_stall,
  output logic [$clog2(NUM_PR)-1:0]            PR_new,
  output logic                                 empty,
  input  logic                                 retire_reg,
  input  logic                                 RegDest_retire,
  input  logic [$clog2(NUM_PR)-1:0]            PR_old_RT,
  input  logic                                 recover,
  input  logic                                 RegDest_out,
  input  logic [$clog2(NUM_PR)-1:0]            PR_new_flush,
  output logic [$clog2(NUM_PR-NUM_AR+1)-1:0]   free_count,
  output logic                                 overflow
);

  localparam int unsigned TAG_W   = $clog2(NUM_PR);
  localparam int unsigned DEPTH   = NUM_PR - NUM_AR;
  // Pointers wrap naturally, so DEPTH is expected to be a power of two.
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned SPACE_W = CNT_W + 1;

  logic [TAG_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;

  logic               pop;
  logic               push_flush;
  logic               push_retire;
  logic [1:0]         req_n;
  logic [1:0]         acc_n;
  logic [SPACE_W-1:0] space;
  logic               drop;
  logic [TAG_W-1:0]   wr_tag0;
  logic [TAG_W-1:0]   wr_tag1;

  assign PR_new     = mem[head];
  assign empty      = (count == '0);
  assign free_count = count;

  // Push/pop decode; the pop frees a slot usable by a push in the same cycle.
  always_comb begin
    pop         = alloc & ~hazard_stall & ~recover & ~empty;
    push_flush  = recover & RegDest_out;
    push_retire = retire_reg & RegDest_retire;
    req_n       = 2'(push_flush) + 2'(push_retire);
    space       = SPACE_W'(DEPTH) - SPACE_W'(count) + SPACE_W'(pop);
    acc_n       = req_n;
    // Excess pushes are dropped; the flush tag has priority for the last slot.
    if (SPACE_W'(req_n) > space) begin
      acc_n = 2'(space);
    end
    drop    = (acc_n != req_n);
    wr_tag0 = push_flush ? PR_new_flush : PR_old_RT;
    wr_tag1 = PR_old_RT;
  end

  // Storage, pointers, count and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[PTR_W'(i)] <= TAG_W'(NUM_AR + i);
      end
      head     <= '0;
      tail     <= '0;
      count    <= CNT_W'(DEPTH);
      overflow <= 1'b0;
    end else begin
      if (acc_n != 2'd0) begin
        mem[tail] <= wr_tag0;
      end
      if (acc_n == 2'd2) begin
        mem[tail + PTR_W'(1)] <= wr_tag1;
      end
      tail  <= tail + PTR_W'(acc_n);
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      count <= count + CNT_W'(acc_n) - CNT_W'(pop);
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter NUM_PR, default 64, meaning total physical registers (6-bit tags).
REQ-002 SHALL have parameter NUM_AR, default 32, meaning architectural registers permanently mapped at any time; FIFO depth = NUM_PR-NUM_AR = 32.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port alloc  input  1  dispatch request for a new physical register (isDispatch & RegDest).
REQ-006 SHALL have port hazard_stall  input  1  pipeline stall; blocks allocation.
REQ-007 SHALL have port PR_new  output  6  tag offered to dispatch (FIFO head, fall-through).
REQ-008 SHALL have port empty  output  1  no free register; dispatch must stall.
REQ-009 SHALL have port retire_reg  input  1  ROB retiring an instruction.
REQ-010 SHALL have port RegDest_retire  input  1  retiring instruction wrote a register.
REQ-011 SHALL have port PR_old_RT  input  6  superseded tag released at retire.
REQ-012 SHALL have port recover  input  1  ROB rollback in progress, one entry per cycle.
REQ-013 SHALL have port RegDest_out  input  1  flushed entry wrote a register.
REQ-014 SHALL have port PR_new_flush  input  6  speculative tag released on flush.
REQ-015 SHALL have port free_count  output  6  number of free tags, 0..32.
REQ-016 SHALL have port overflow  output  1  sticky error: push beyond depth or duplicate-free violation of count.

Function
REQ-017 SHALL store tags in a 32x6 circular buffer with 5-bit head, 5-bit tail and 6-bit count; pointers wrap 31->0.
REQ-018 SHALL drive PR_new = mem[head] combinationally and empty = (count==0).
REQ-019 SHALL pop (head+1, count-1) on a cycle where alloc & !hazard_stall & !recover & !empty; otherwise no pop.
REQ-020 SHALL ignore alloc while empty (no pop, no count change, no error), while hazard_stall, and while recover.
REQ-021 SHALL push PR_old_RT when retire_reg & RegDest_retire.
REQ-022 SHALL push PR_new_flush when recover & RegDest_out.
REQ-023 SHALL accept both pushes in one cycle: flush tag written at tail, retire tag at tail+1, tail advanced by 2.
REQ-024 SHALL compute next count = count + pushes - pop (pushes 0..2, pop 0..1) in one cycle; pop and push in the same cycle both take effect.
REQ-025 SHALL not bypass: a tag pushed in cycle N is available at PR_new no earlier than cycle N+1, and only when it reaches head.
REQ-026 SHALL, if count + pushes - pop would exceed 32, drop the excess pushes (mem, tail, count unchanged for dropped writes), saturate count at 32 and set overflow until reset.
REQ-027 SHALL have 1-cycle latency from push edge to free_count/empty update.

Reset
REQ-028 SHALL, on rst high at a clock edge, set mem[i]=32+i for i=0..31, head=0, tail=0, count=32, overflow=0, overriding every simultaneous alloc/push.
REQ-029 SHALL present PR_new=6'h20, empty=0, free_count=32 in the cycle after reset; reset asserted mid-operation discards all in-flight state identically.

Verification
REQ-030 Reset then alloc for 3 cycles -> PR_new sequence 0x20,0x21,0x22; free_count 31,30,29; PR_new=0x23 afterwards.
REQ-031 Alloc 32 consecutive cycles -> free_count 0, empty=1; alloc held further -> no pop, PR_new stable, overflow=0.
REQ-032 From empty, retire_reg=1, RegDest_retire=1, PR_old_RT=0x05 -> next cycle empty=0, free_count=1, PR_new=0x05; RegDest_retire=0 instead -> no change.
REQ-033 Count=29, same cycle recover=1/RegDest_out=1/PR_new_flush=0x27 and retire of PR_old_RT=0x03 with alloc=1 -> alloc ignored, count 31, 0x27 then 0x03 queued at tail order.
REQ-034 Count=30 with head at 2, alloc & !hazard_stall plus single retire push -> count stays 30, head=3, tail advances 1; hazard_stall=1 same stimulus -> count 31, head unchanged.
REQ-035 Count=32 (post-reset), push PR_old_RT=0x01 -> overflow=1 sticky, count stays 32, mem unchanged; rst -> overflow=0.
